// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: ALU op codes, legality check and scheduler state encoding shared by the scheduler files.
package alu_sched_pkg;
  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_XOR   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_AND   = 5'b00100;
  localparam logic [4:0] ALU_SLL   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_SLT   = 5'b01000;
  localparam logic [4:0] ALU_SLTU  = 5'b01101;
  localparam logic [4:0] ALU_EQ    = 5'b10000;
  localparam logic [4:0] ALU_NE    = 5'b10001;
  localparam logic [4:0] ALU_LT    = 5'b10100;
  localparam logic [4:0] ALU_GE    = 5'b10101;
  localparam logic [4:0] ALU_LTU   = 5'b10110;
  localparam logic [4:0] ALU_GEU   = 5'b10111;
  localparam logic [4:0] ALU_PASSB = 5'b11111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} sched_state_e;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
      ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU, ALU_PASSB: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts one past ptr_i and wraps.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int k;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    k = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o = 1'b1;
        idx_o = IW'(k);
      end
    end
    gnt_o = any_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
  end
endmodule

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin shares one combinational ALU between NREQ requesters,
// with registered operands, registered result and per-requester valid/ready responses.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*XLEN-1:0] req_a_i,
  input  logic [NREQ*XLEN-1:0] req_b_i,
  input  logic [NREQ*OPW-1:0]  req_op_i,
  output logic [XLEN-1:0]      alu_a_o,
  output logic [XLEN-1:0]      alu_b_o,
  output logic [OPW-1:0]       alu_op_o,
  input  logic [XLEN-1:0]      alu_d_i,
  input  logic                 alu_branch_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]      rsp_data_o,
  output logic                 rsp_branch_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);
  localparam int IW = $clog2(NREQ);

  sched_state_e    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, tag_q, tag_d, win;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0]  op_q, op_d, win_op;
  logic            err_q, err_d, br_q, br_d;
  logic [NREQ-1:0] gnt;
  logic            any_req, hs, grant_en, accept, drive_alu;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any_req)
  );

  // A completing response handshake re-opens arbitration in the same cycle.
  always_comb begin
    hs = (state_q == S_RESP) && rsp_ready_i[tag_q];
    grant_en = rst_ni && ((state_q == S_IDLE) || hs);
    accept = grant_en && any_req;
    req_ready_o = grant_en ? gnt : '0;
    win_op = req_op_i[int'(win)*OPW +: OPW];
    state_d = accept ? S_EXEC : (state_q == S_EXEC) ? S_RESP : (state_q == S_RESP && !hs) ? S_RESP : S_IDLE;
    ptr_d = accept ? win : ptr_q;
    tag_d = accept ? win : tag_q;
    a_d = accept ? req_a_i[int'(win)*XLEN +: XLEN] : a_q;
    b_d = accept ? req_b_i[int'(win)*XLEN +: XLEN] : b_q;
    op_d = accept ? win_op : op_q;
    err_d = accept ? ~is_legal_op(win_op) : err_q;
    res_d = (state_q == S_EXEC) ? (err_q ? '0 : alu_d_i) : res_q;
    br_d = (state_q == S_EXEC) ? (!err_q && alu_branch_i) : br_q;
    drive_alu = (state_q != S_IDLE) && !err_q;
    alu_a_o = drive_alu ? a_q : '0;
    alu_b_o = drive_alu ? b_q : '0;
    alu_op_o = drive_alu ? op_q : '0;
    rsp_valid_o = (state_q == S_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_q) : '0;
    rsp_data_o = (state_q == S_RESP) ? res_q : '0;
    rsp_branch_o = (state_q == S_RESP) && br_q;
    rsp_err_o = (state_q == S_RESP) && err_q;
    busy_o = state_q != S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q <= IW'(NREQ - 1);
      tag_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      err_q <= 1'b0;
      res_q <= '0;
      br_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      err_q <= err_d;
      res_q <= res_d;
      br_q <= br_d;
    end
  end
endmodule
